// File: rtl/envelope_vca_pkg.sv
// Shared audio package: Q1.(W-1) helpers and the common sample type used by the
// envelope generator, the VCA and the mixer.
package envelope_vca_pkg;

  localparam int AUDIO_WIDTH = 16;

  typedef logic signed [AUDIO_WIDTH-1:0] sample_t;

  // Largest positive Q1.(w-1) value, treated as gain 1.0.
  function automatic int unity_level(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Half an LSB of the Q1.(w-1) product, added before the shift to round half up.
  function automatic int round_offset(input int w);
    return 1 << (w - 2);
  endfunction

  localparam int UNITY_LEVEL  = unity_level(AUDIO_WIDTH);
  localparam int ROUND_OFFSET = round_offset(AUDIO_WIDTH);

endpackage

// File: rtl/envelope_vca_if.sv
// Sample stream in/out of the VCA plus the envelope target and activity flag.
// valid/ready: a beat moves on a rising edge where valid and ready are both high;
// once valid is raised, data is held stable until that edge.
interface envelope_vca_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid_i;
  logic                         ready_o;
  logic signed [DATA_WIDTH-1:0] sample_i;
  logic signed [DATA_WIDTH-1:0] envelope_i;
  logic                         valid_o;
  logic                         ready_i;
  logic signed [DATA_WIDTH-1:0] sample_o;
  logic                         active_o;

  modport master (
    output valid_i, sample_i, envelope_i, ready_i,
    input  ready_o, valid_o, sample_o, active_o
  );

  modport slave (
    input  valid_i, sample_i, envelope_i, ready_i,
    output ready_o, valid_o, sample_o, active_o
  );
endinterface

// File: rtl/envelope_vca_slew.sv
// Slew-limited copy of the envelope target: clamps negatives to zero and moves
// the applied level at most SLEW_STEP per accepted sample.
module envelope_vca_slew #(
  parameter int DATA_WIDTH = 16,
  parameter int SLEW_STEP  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  accept,
  input  logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] env_next,
  output logic                  active
);

  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(SLEW_STEP);

  logic [DATA_WIDTH-1:0] env_q;
  logic [DATA_WIDTH-1:0] tgt;

  // Both tgt and env_q are non-negative, so unsigned arithmetic never wraps here.
  always_comb begin
    tgt      = target[DATA_WIDTH-1] ? '0 : target;
    env_next = tgt;
    if (SLEW_STEP != 0) begin
      if (tgt > env_q) begin
        if ((tgt - env_q) > STEP) env_next = env_q + STEP;
      end else if ((env_q - tgt) > STEP) begin
        env_next = env_q - STEP;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      env_q  <= '0;
      active <= 1'b0;
    end else if (accept) begin
      env_q  <= env_next;
      active <= (env_next != '0);
    end
  end

endmodule

// File: rtl/envelope_vca.sv
// Voltage-controlled amplifier: multiplies each accepted sample by the slewed
// envelope level, then rounds back to Q1.(W-1) in a second register stage.
module envelope_vca
  import envelope_vca_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SLEW_STEP  = 64
) (
  input logic            clk_i,
  input logic            rst_ni,
  envelope_vca_if.slave  bus
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [PW-1:0] ROUND   = PW'(round_offset(DATA_WIDTH));
  localparam logic signed [PW-1:0] RES_MAX = PW'(unity_level(DATA_WIDTH));

  logic                         s1_valid, s2_valid;
  logic                         s1_ready, s2_ready;
  logic                         accept;
  logic signed [PW-1:0]         s1_prod;
  logic signed [PW-1:0]         rounded;
  logic signed [DATA_WIDTH-1:0] s2_data;
  logic [DATA_WIDTH-1:0]        env_next;
  logic signed [DATA_WIDTH-1:0] env_s;
  logic                         in_range;

  assign s2_ready    = !s2_valid || bus.ready_i;
  assign s1_ready    = !s1_valid || s2_ready;
  assign bus.ready_o = s1_ready;
  assign accept      = bus.valid_i && s1_ready;

  envelope_vca_slew #(
    .DATA_WIDTH (DATA_WIDTH),
    .SLEW_STEP  (SLEW_STEP)
  ) u_slew (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .accept   (accept),
    .target   (bus.envelope_i),
    .env_next (env_next),
    .active   (bus.active_o)
  );

  // env_next never exceeds the unity level, so its MSB is zero and it is safe as signed.
  assign env_s    = $signed(env_next);
  assign rounded  = (s1_prod + ROUND) >>> (DATA_WIDTH - 1);
  assign in_range = (rounded <= RES_MAX) && (rounded >= -RES_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_prod  <= bus.sample_i * env_s;
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s1_valid && s2_ready) begin
      s2_valid <= 1'b1;
      s2_data  <= rounded[DATA_WIDTH-1:0];
    end else if (bus.ready_i) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.sample_o = s2_data;
  assign bus.valid_o  = s2_valid;

  a_range : assert property (@(posedge clk_i) disable iff (!rst_ni) s1_valid |-> in_range)
    else $error("envelope_vca: rounded product out of range");

endmodule

// File: doc/envelope_vca.md
# envelope_vca

- Voltage-controlled amplifier that applies the ADSR envelope to the audio sample stream.
- Consumes the envelope level produced by the envelope generator; multiplies each accepted signed sample by a slew-limited copy of that level.
- Emits the scaled stream to the downstream mixer/DAC path over a valid/ready handshake.
- Two-stage pipeline with full throughput and lossless backpressure.

## Interface
Parameters:
- DATA_WIDTH, 16: width of samples, envelope level and output.
- SLEW_STEP, 64: maximum change of the applied envelope per accepted sample; 0 disables slew limiting (target applied directly).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset. Asynchronous assert, active-low.
- envelope_i  input  DATA_WIDTH  signed envelope target in Q1.(DATA_WIDTH-1); 2^(DATA_WIDTH-1)-1 = unity, negative values clamp to 0.
- valid_i  input  1  sample_i is valid.
- ready_o  output  1  block accepts sample_i this cycle.
- sample_i  input  DATA_WIDTH  signed audio sample.
- valid_o  output  1  sample_o is valid.
- ready_i  input  1  downstream accepts sample_o.
- sample_o  output  DATA_WIDTH  signed scaled sample.
- active_o  output  1  applied envelope (env_q) is non-zero.

## Operation
- Accept: valid_i && ready_o on a rising edge.
- Target: tgt = envelope_i < 0 ? 0 : envelope_i, sampled only on accept.
- Slew: env_next = env_q moved toward tgt by min(|tgt - env_q|, SLEW_STEP); if SLEW_STEP == 0, env_next = tgt.
  - env_q <= env_next on accept only; held otherwise.
  - env_q never overshoots tgt.
- Stage 1 on accept: s1_prod <= sample_i * env_next, signed, 2*DATA_WIDTH bits; s1_valid <= 1.
- Stage 2: s2_data <= (s1_prod + 2^(DATA_WIDTH-2)) >>> (DATA_WIDTH-1), i.e. round half up, truncated to DATA_WIDTH.
  - Since env ≤ 2^(DATA_WIDTH-1)-1, |result| ≤ 2^(DATA_WIDTH-1)-1, so no saturation logic is needed.
  - Assert on the internal range check in simulation.
- sample_o = s2_data; valid_o = s2_valid.
- Ready chain:
  - s2_ready = !s2_valid || ready_i
  - s1_ready = !s1_valid || s2_ready
  - ready_o = s1_ready (combinational from ready_i).
- Stage advance:
  - s2 loads from s1 when s1_valid && s2_ready.
  - s2_valid clears when output is consumed with no s1 data moving in.
  - s1_valid clears likewise.
- Ordering: strict FIFO order, no drops, no duplicates.
- active_o = (env_q != 0), registered alongside env_q.

## Timing
- Reset values: valid_o = 0, sample_o = 0, active_o = 0, env_q = 0, s1_valid = 0, s2_valid = 0.
  - ready_o = 1 combinationally once out of reset.
- Latency: 2 cycles from accept to valid_o when ready_i = 1. A sample accepted at edge N is visible on sample_o after edge N+1.
- Throughput: 1 sample/cycle while ready_i = 1.
- Backpressure: with ready_i held low, at most 2 samples are buffered (s1, s2), then ready_o = 0.
  - ready_i rising releases one sample per cycle.
- Output stability: sample_o is held stable while valid_o && !ready_i.
- Envelope application: envelope_i changes between accepts have no effect. The envelope applied to a sample is env_next at that sample's accept edge.
- Reset mid-stream: in-flight samples are discarded, env_q returns to 0, and the first post-reset sample slews from 0.
- Simultaneous events: consume at s2 and load from s1 in the same cycle is a pass-through with no bubble.

## Structure
- Shared audio package: Q-format constants (unity level, rounding offset for DATA_WIDTH) and a sample_t typedef, reused by the envelope generator and mixer.
- One natural sub-module: envelope_slew (env_q register, clamp, step toward target, active_o). The multiply/round pipeline stays in the top.

## Test plan
- Unity gain, SLEW_STEP=0, envelope_i=32767, sample_i=1000 → sample_o=1000 exactly 2 cycles after accept. Same for -1000 → -1000.
- Half gain, SLEW_STEP=0, envelope_i=16384, sample_i=-20000 → sample_o=-10000; sample_i=-32768, envelope_i=32767 → -32767 with no range-check assertion.
- Negative envelope: envelope_i=-5000, sample_i=12345 → sample_o=0 and active_o=0.
- Slew, SLEW_STEP=64:
  - envelope_i held at 32767 with a continuous stream of sample_i=32767 → env_q=64·N after N accepts, reaching 32767 at accept 512.
  - Then envelope_i=0 → env_q decreases by 64 per accept to exactly 0, and active_o falls on that edge.
- Backpressure: stream 0..9 with ready_i low for 5 cycles starting at cycle 3 → ready_o low after two buffered beats; sample_o stable while stalled; all 10 samples arrive in order with none lost.
- Async reset mid-stream: assert rst_ni between clock edges with 2 samples in flight → valid_o, active_o and sample_o go to 0 immediately. After release, a sample with envelope_i=32767 and SLEW_STEP=64 yields env_q=64.
